// File: rtl/riscv_regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
// Word-count derivation and write-port priority selection.
package riscv_regfile_pkg;

  localparam int MAX_PORTS = 4;

  function automatic int num_words(input int aw);
    return 1 << aw;
  endfunction

  // Highest-index set bit wins; callers only use it when hit != 0.
  function automatic logic [1:0] prio_sel(
    input logic [MAX_PORTS-1:0] hit
  );
    logic [1:0] sel;
    sel = 2'd0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (hit[i]) sel = 2'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// Busy-bit array and pending counter for the register file.
// A writeback clear and a new issue to one word leave it busy.
module riscv_regfile_scoreboard
  import riscv_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WPORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  iss_valid,
  input  logic [ADDR_WIDTH-1:0]                 iss_addr,
  input  logic [NUM_WPORTS-1:0]                 we,
  input  logic [NUM_WPORTS-1:0]                 wclr,
  input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr,
  output logic [num_words(ADDR_WIDTH)-1:0]      busy,
  output logic                                  iss_ready,
  output logic [ADDR_WIDTH:0]                   pending_cnt
);

  localparam int NUM_WORDS = num_words(ADDR_WIDTH);

  logic [NUM_WORDS-1:0] busy_q;
  logic [NUM_WORDS-1:0] busy_d;
  logic [ADDR_WIDTH:0]  cnt_q;
  logic [ADDR_WIDTH:0]  cnt_d;
  logic                 clr_hit;
  logic                 iss_zero;

  // Issue acceptance: free word, or freed by a writeback this cycle.
  always_comb begin
    clr_hit = 1'b0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (we[p] && wclr[p] && waddr[p] == iss_addr) clr_hit = 1'b1;
    end
    iss_zero  = (ZERO_REG != 0) && (iss_addr == '0);
    iss_ready = !busy_q[iss_addr] || clr_hit;
  end

  // Next busy state: clears first, then the accepted issue sets.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (we[p] && wclr[p]) busy_d[waddr[p]] = 1'b0;
    end
    if (iss_valid && iss_ready && !iss_zero) busy_d[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[w]};
    end
  end

  // Busy bits and their population count update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;

endmodule

// File: rtl/riscv_regfile_scb.sv
// Multi-ported register file with per-word pending scoreboard.
// Optional word-0 hardwiring and same-cycle write forwarding.
module riscv_regfile_scb
  import riscv_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3,
  parameter int NUM_WPORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  test_en_i,
  input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]                 rbusy_o,
  input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WPORTS-1:0]                 we_i,
  input  logic [NUM_WPORTS-1:0]                 wclr_i,
  input  logic                                  iss_valid_i,
  input  logic [ADDR_WIDTH-1:0]                 iss_addr_i,
  output logic                                  iss_ready_o,
  output logic [ADDR_WIDTH:0]                   pending_cnt_o
);

  localparam int NUM_WORDS = num_words(ADDR_WIDTH);

  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  mem;
  logic [NUM_WORDS-1:0]                  busy;
  logic [MAX_PORTS-1:0][DATA_WIDTH-1:0]  wdata_pad;
  logic [MAX_PORTS-1:0][ADDR_WIDTH-1:0]  waddr_pad;
  logic [MAX_PORTS-1:0]                  we_pad;
  logic [NUM_RPORTS-1:0][MAX_PORTS-1:0]  rhit;
  logic                                  unused_test_en;

  assign unused_test_en = test_en_i;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Widen write ports to the fixed priority-select width.
  always_comb begin
    wdata_pad = '0;
    waddr_pad = '0;
    we_pad    = '0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      wdata_pad[p] = wdata_i[p];
      waddr_pad[p] = waddr_i[p];
      we_pad[p]    = we_i[p];
    end
  end

  // Storage: later ports override earlier ones on the same word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (we_i[p] && !is_zero(waddr_i[p])) begin
          mem[waddr_i[p]] <= wdata_i[p];
        end
      end
    end
  end

  // Read ports with optional forwarding and busy lookup.
  always_comb begin
    rhit    = '0;
    rdata_o = '0;
    rbusy_o = '0;
    for (int r = 0; r < NUM_RPORTS; r++) begin
      for (int p = 0; p < MAX_PORTS; p++) begin
        rhit[r][p] = we_pad[p] && (waddr_pad[p] == raddr_i[r]);
      end
      rdata_o[r] = mem[raddr_i[r]];
      if ((BYPASS != 0) && (|rhit[r])) begin
        rdata_o[r] = wdata_pad[prio_sel(rhit[r])];
      end
      if (is_zero(raddr_i[r])) rdata_o[r] = '0;
      rbusy_o[r] = busy[raddr_i[r]];
    end
  end

  riscv_regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WPORTS (NUM_WPORTS),
    .ZERO_REG   (ZERO_REG)
  ) u_scb (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid_i),
    .iss_addr    (iss_addr_i),
    .we          (we_i),
    .wclr        (wclr_i),
    .waddr       (waddr_i),
    .busy        (busy),
    .iss_ready   (iss_ready_o),
    .pending_cnt (pending_cnt_o)
  );

endmodule

// File: tb/tb_riscv_regfile_scb.sv
// Directed bench for riscv_regfile_scb.
// Vector table plus issue-storm and mid-stream reset sequences.
module tb_riscv_regfile_scb;

  logic             clk;
  logic             rst_n;
  logic             test_en;
  logic [2:0][4:0]  raddr;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]       we;
  logic [1:0]       wclr;
  logic             iv;
  logic [4:0]       ia;

  logic [2:0][31:0] rdata;
  logic [2:0]       rbusy;
  logic             rdy;
  logic [5:0]       cnt;
  logic [2:0][31:0] rdata_b;
  logic [2:0]       rbusy_b;
  logic             rdy_b;
  logic [5:0]       cnt_b;

  int n_cmp;
  int n_err;

  riscv_regfile_scb #(.BYPASS(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .test_en_i     (test_en),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rbusy_o       (rbusy),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .we_i          (we),
    .wclr_i        (wclr),
    .iss_valid_i   (iv),
    .iss_addr_i    (ia),
    .iss_ready_o   (rdy),
    .pending_cnt_o (cnt)
  );

  riscv_regfile_scb #(.BYPASS(1)) dut_bp (
    .clk           (clk),
    .rst_n         (rst_n),
    .test_en_i     (test_en),
    .raddr_i       (raddr),
    .rdata_o       (rdata_b),
    .rbusy_o       (rbusy_b),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .we_i          (we),
    .wclr_i        (wclr),
    .iss_valid_i   (iv),
    .iss_addr_i    (ia),
    .iss_ready_o   (rdy_b),
    .pending_cnt_o (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    we    = '0;
    wclr  = '0;
    waddr = '0;
    wdata = '0;
    iv    = 1'b0;
    ia    = '0;
    raddr = '0;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [1:0]  wclr;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  ra;
    logic [31:0] erd;
    logic [31:0] erdb;
    logic        ebusy;
    logic        erdy;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t tv[14];

  initial begin
    // we wclr wa0 wa1 wd0 wd1 iv ia ra | rd rd_bp busy rdy cnt
    tv[0]  = '{2'b11, 2'b00, 5'd5, 5'd5, 32'h11, 32'h22, 1'b0, 5'd0, 5'd5,
               32'h0, 32'h22, 1'b0, 1'b1, 6'd0};
    tv[1]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5,
               32'h22, 32'h22, 1'b0, 1'b1, 6'd0};
    tv[2]  = '{2'b01, 2'b00, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 5'd0,
               5'd7, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, 6'd0};
    tv[3]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7,
               32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b1, 6'd0};
    tv[4]  = '{2'b11, 2'b00, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
               5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 6'd0};
    tv[5]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0,
               32'h0, 32'h0, 1'b0, 1'b1, 6'd0};
    tv[6]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3,
               32'h0, 32'h0, 1'b0, 1'b1, 6'd0};
    tv[7]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3,
               32'h0, 32'h0, 1'b1, 1'b0, 6'd1};
    tv[8]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3,
               32'h0, 32'h0, 1'b1, 1'b0, 6'd1};
    tv[9]  = '{2'b10, 2'b10, 5'd0, 5'd3, 32'h0, 32'h33, 1'b1, 5'd3, 5'd3,
               32'h0, 32'h33, 1'b1, 1'b1, 6'd1};
    tv[10] = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd3,
               32'h33, 32'h33, 1'b1, 1'b0, 6'd1};
    tv[11] = '{2'b00, 2'b01, 5'd3, 5'd0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd3,
               32'h33, 32'h33, 1'b1, 1'b0, 6'd1};
    tv[12] = '{2'b01, 2'b01, 5'd3, 5'd0, 32'h44, 32'h0, 1'b0, 5'd3, 5'd3,
               32'h33, 32'h44, 1'b1, 1'b1, 6'd1};
    tv[13] = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd3,
               32'h44, 32'h44, 1'b0, 1'b1, 6'd0};

    n_cmp   = 0;
    n_err   = 0;
    test_en = 1'b0;
    rst_n   = 1'b0;
    idle();
    #12;
    chk("rst_rdata0", rdata[0], 32'h0);
    chk("rst_rbusy", {29'd0, rbusy}, 32'h0);
    chk("rst_ready", {31'd0, rdy}, 32'h1);
    chk("rst_cnt", {26'd0, cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      we       = tv[i].we;
      wclr     = tv[i].wclr;
      waddr[0] = tv[i].wa0;
      waddr[1] = tv[i].wa1;
      wdata[0] = tv[i].wd0;
      wdata[1] = tv[i].wd1;
      iv       = tv[i].iv;
      ia       = tv[i].ia;
      raddr    = '0;
      raddr[0] = tv[i].ra;
      #1;
      chk($sformatf("v%0d_rdata", i), rdata[0], tv[i].erd);
      chk($sformatf("v%0d_rdata_bp", i), rdata_b[0], tv[i].erdb);
      chk($sformatf("v%0d_rbusy", i), {31'd0, rbusy[0]},
          {31'd0, tv[i].ebusy});
      chk($sformatf("v%0d_ready", i), {31'd0, rdy}, {31'd0, tv[i].erdy});
      chk($sformatf("v%0d_cnt", i), {26'd0, cnt}, {26'd0, tv[i].ecnt});
    end

    // Issue storm: x1..x31 back to back, one per cycle.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      idle();
      iv = 1'b1;
      ia = 5'(i);
      #1;
      chk($sformatf("storm%0d_ready", i), {31'd0, rdy}, 32'h1);
      chk($sformatf("storm%0d_cnt", i), {26'd0, cnt}, 32'(i - 1));
    end
    @(negedge clk);
    idle();
    raddr[0] = 5'd1;
    raddr[1] = 5'd17;
    raddr[2] = 5'd31;
    ia       = 5'd3;
    #1;
    chk("storm_cnt", {26'd0, cnt}, 32'd31);
    chk("storm_rbusy", {29'd0, rbusy}, 32'h7);
    chk("storm_ready_x3", {31'd0, rdy}, 32'h0);

    // Reset mid-stream with a write and an issue in flight.
    @(negedge clk);
    we[0]    = 1'b1;
    waddr[0] = 5'd9;
    wdata[0] = 32'h99;
    wclr[0]  = 1'b1;
    iv       = 1'b1;
    ia       = 5'd3;
    raddr[0] = 5'd5;
    raddr[1] = 5'd7;
    raddr[2] = 5'd3;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_cnt", {26'd0, cnt}, 32'h0);
    chk("mid_rst_rbusy", {29'd0, rbusy}, 32'h0);
    chk("mid_rst_ready", {31'd0, rdy}, 32'h1);
    chk("mid_rst_rd0", rdata[0], 32'h0);
    chk("mid_rst_rd1", rdata[1], 32'h0);
    chk("mid_rst_rd2", rdata[2], 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_cnt", {26'd0, cnt}, 32'h0);
    for (int w = 0; w < 32; w++) begin
      raddr[0] = 5'(w);
      raddr[1] = 5'(31 - w);
      #1;
      chk($sformatf("post_rst_rd_x%0d", w), rdata[0], 32'h0);
      chk($sformatf("post_rst_busy_x%0d", w), {31'd0, rbusy[1]}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
